// File: rtl/spi_rx_slave.sv
// SPI mode-0 receiver: oversampled sclk/mosi/cs_n/dc, MSB-first words
// tagged with D/C, delivered through a one-entry valid/ready register.
module spi_rx_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  input  logic              spi_dc,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_dc,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_end,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_END
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_s;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic [SYNC_STAGES-1:0] cs_s;
  logic [SYNC_STAGES-1:0] dc_s;
  logic [SYNC_STAGES-1:0] fill;
  logic                   sclk_q;
  logic                   cs_q;
  logic                   armed;

  logic sclk_y, mosi_y, cs_y, dc_y;
  logic sclk_rise, cs_fall, cs_rise;

  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] shift_q, shift_d, word;
  logic              done, err_d;
  logic              load, drop;

  assign sclk_y = sclk_s[SYNC_STAGES-1];
  assign mosi_y = mosi_s[SYNC_STAGES-1];
  assign cs_y   = cs_s[SYNC_STAGES-1];
  assign dc_y   = dc_s[SYNC_STAGES-1];

  assign sclk_rise = sclk_y & ~sclk_q;
  assign cs_rise   = cs_y & ~cs_q;
  // cs_n low at reset release must first be seen high before a frame opens
  assign cs_fall   = armed & cs_q & ~cs_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s <= '0;
      mosi_s <= '0;
      cs_s   <= '1;
      dc_s   <= '0;
      fill   <= '0;
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi_sclk};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], spi_cs_n};
      dc_s   <= {dc_s[SYNC_STAGES-2:0], spi_dc};
      fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_q <= sclk_y;
      cs_q   <= cs_y;
      if (fill[SYNC_STAGES-1] && cs_y) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      frame_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    cnt_inc = cnt_q + CW'(sclk_rise);
    word    = shift_q;
    done    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      S_ACTIVE: begin
        if (sclk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_y};
        end
        if (cnt_q == FULL) begin
          done  = 1'b1;
          cnt_d = CW'(sclk_rise);
        end else begin
          cnt_d = cnt_inc;
          // last bit and cs_rise together: finish the word first
          if (cs_rise && cnt_inc == FULL) begin
            done = 1'b1;
            word = shift_d;
          end
        end
        if (cs_rise) begin
          state_d = S_END;
          cnt_d   = '0;
          err_d   = ~done & (cnt_inc != '0);
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign frame_end = (state_q == S_END);

  assign load = done & (~rx_valid | rx_ready);
  assign drop = done & rx_valid & ~rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_dc    <= 1'b0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= word;
        rx_dc    <= dc_y;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_rx_slave.md
Name: spi_rx_slave

Overview:
SPI mode-0 receiver: the far end of the 4-wire link driven by the display SPI master (sclk, mosi, cs_n, dc).
- Oversamples the link with the local system clock and assembles MSB-first bytes, each tagged with its D/C level.
- Presents bytes on a one-entry valid/ready holding register.
- Used as the on-chip loopback checker for the ILI9341 transmit path, and as the front end of the display command-decoder model.

Parameters:
DATA_W, 8, bits per word; bit counter width is $clog2(DATA_W)+1.
SYNC_STAGES, 2, flip-flops in each input synchronizer (minimum 2).

Ports:
clk        input   1        system clock; must be at least 4x the sclk frequency
rst        input   1        asynchronous active-low reset
spi_sclk   input   1        serial clock from the master; idles low
spi_mosi   input   1        serial data, MSB first
spi_cs_n   input   1        chip select, active low
spi_dc     input   1        data/command line: 0 = command, 1 = data
rx_data    output  DATA_W   received word
rx_dc      output  1        D/C level captured with the word
rx_valid   output  1        holding register full
rx_ready   input   1        consumer accepts the word (rx_valid & rx_ready)
frame_end  output  1        one-cycle pulse when cs_n deasserts
frame_err  output  1        one-cycle pulse when cs_n deasserts mid-word
overrun    output  1        sticky: a word was lost
clr_ovr    input   1        synchronous clear of overrun

Behaviour:
- Reset (rst low, async): every output is 0, the FSM is in IDLE, the shift register and bit counter are 0, and all synchronizers are cleared to their idle levels (sclk 0, cs_n 1).
- Synchronization:
  - sclk, mosi, cs_n and dc each pass through a SYNC_STAGES-deep synchronizer.
  - A further register on synced sclk and synced cs_n gives edge detection.
  - sclk_rise = synced sclk 1 with previous value 0.
  - cs_fall and cs_rise are defined the same way on synced cs_n.
- FSM states: IDLE, ACTIVE, END.
  - IDLE: on cs_fall, go to ACTIVE; bit counter set to 0.
  - ACTIVE, on sclk_rise: shift in synced mosi at the LSB end (MSB first), bit counter +1.
  - ACTIVE, when the counter reaches DATA_W on that edge: the word is complete.
    - The assembled word and the synced dc value go to the holding register.
    - The counter returns to 0.
  - ACTIVE, on cs_rise: go to END. If the counter is non-zero, discard the partial word and pulse frame_err.
  - END: pulse frame_end for one cycle, then go to IDLE.
  - sclk_rise while in IDLE or END is ignored.
- Word-complete latency: rx_valid rises SYNC_STAGES+1 clk edges after the first clk edge that samples spi_sclk high on the last bit.
- Holding register:
  - rx_valid is set on word-complete and cleared on rx_valid & rx_ready.
  - rx_data and rx_dc are stable while rx_valid is high.
- Simultaneous events:
  - Word-complete with rx_valid=1 and rx_ready=1 in the same cycle: the new word replaces the old one and rx_valid stays 1. No overrun.
  - Word-complete with rx_valid=1 and rx_ready=0: the new word is dropped, the old word is kept, and overrun is set.
  - clr_ovr in the same cycle as a new overrun: set wins.
  - cs_rise in the same cycle as the final sclk_rise is impossible after synchronization; if it occurs, the word completes first, then END is taken with no frame_err.
- Back-to-back words within one cs_n window are supported with no gap cycles; the counter wraps DATA_W -> 0 automatically.
- Mid-operation reset: the state is abandoned immediately and no pulses are issued. After reset, a cs_n that is already low is not treated as a frame start until cs_n goes high and then low again (the synchronizer idles at 1).
- Mode 0 only: the master changes mosi on sclk falling edges, and the receiver samples only on rising edges.

Test Plan:
1. cs_n low, send 0xA5 with dc=1, rx_ready held 1 -> one rx_valid pulse with rx_data=0xA5, rx_dc=1, then a frame_end pulse; overrun=0 and frame_err=0.
2. One cs_n window carrying 0x2A (dc=0) then 0x00,0x10 (dc=1), rx_ready=1 -> three words in order with rx_dc values 0,1,1 and exactly one frame_end.
3. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun=1. Then rx_ready=1 -> rx_valid clears. Then clr_ovr -> overrun=0.
4. cs_n rises after 5 bits of 0xFF -> frame_err and frame_end both pulse, rx_valid stays 0. The next full frame with 0x3C is received correctly.
5. Assert rst low during bit 4 of 0x81 and release it -> all outputs 0. The next cs_n high-to-low frame with 0x81 yields rx_data=0x81.
6. sclk toggles while cs_n is high, then a frame with 0x5A is sent -> the idle toggles are ignored and rx_data=0x5A. Check the rx_valid latency of SYNC_STAGES+1 edges with SYNC_STAGES=3.
